// File: rtl/quaddectest_cpu_oci_dct_packer.sv
// quaddectest_cpu_oci_dct_packer
// Packs 2-bit trace atoms into a 30-bit frame buffer and hands full or
// flushed frames to the sink over valid/ready. It also sequences the
// end-of-test handshake (test_ending / test_has_ended).
// Optional feature macro: DCT_DROP_COUNT_EN. When it is defined, atoms are
// always accepted, and the atoms that arrive outside FILL are counted in
// drop_count.
module quaddectest_cpu_oci_dct_packer #(
  parameter int ATOM_W = 2,
  parameter int SLOTS  = 15,
  parameter int CNT_W  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      atom_valid,
  input  logic [ATOM_W-1:0]         atom_data,
  output logic                      atom_ready,
  input  logic                      flush,
  input  logic                      stop_req,
  output logic                      frame_valid,
  input  logic                      frame_ready,
  output logic [ATOM_W*SLOTS-1:0]   frame_data,
  output logic [CNT_W-1:0]          frame_count,
  output logic [ATOM_W*SLOTS-1:0]   dct_buffer,
  output logic [CNT_W-1:0]          dct_count,
  output logic                      test_ending,
  output logic                      test_has_ended
`ifdef DCT_DROP_COUNT_EN
  ,
  output logic [15:0]               drop_count
`endif
);

  localparam int BUF_W = ATOM_W * SLOTS;

  typedef enum logic [1:0] {FILL, EMIT, ENDED} state_t;

  state_t             state_q, state_d;
  logic [BUF_W-1:0]   buf_d, fdata_d, packed_buf;
  logic [CNT_W-1:0]   cnt_d, fcnt_d, packed_cnt;
  logic               ending_d;

  assign frame_valid    = (state_q == EMIT);
  assign test_has_ended = (state_q == ENDED);
`ifdef DCT_DROP_COUNT_EN
  assign atom_ready     = 1'b1;
`else
  assign atom_ready     = (state_q == FILL);
`endif

  // Next-state, fill-buffer and frame-capture logic.
  always_comb begin
    state_d    = state_q;
    buf_d      = dct_buffer;
    cnt_d      = dct_count;
    fdata_d    = frame_data;
    fcnt_d     = frame_count;
    ending_d   = test_ending | stop_req;
    packed_buf = dct_buffer;
    packed_cnt = dct_count;
    unique case (state_q)
      FILL: begin
        // The atom of this cycle is packed first, so that a flush or stop in
        // the same cycle captures the frame including that atom.
        if (atom_valid) begin
          for (int unsigned i = 0; i < SLOTS; i++) begin
            if (dct_count == CNT_W'(i)) packed_buf[i*ATOM_W +: ATOM_W] = atom_data;
          end
          packed_cnt = dct_count + CNT_W'(1);
        end
        if (packed_cnt == CNT_W'(SLOTS) ||
            ((flush || stop_req) && packed_cnt != '0)) begin
          fdata_d = packed_buf;
          fcnt_d  = packed_cnt;
          buf_d   = '0;
          cnt_d   = '0;
          state_d = EMIT;
        end else begin
          buf_d = packed_buf;
          cnt_d = packed_cnt;
          if (stop_req) state_d = ENDED;
        end
      end
      EMIT: begin
        // A stop that arrives with the handshake still ends the test.
        if (frame_ready) state_d = (test_ending || stop_req) ? ENDED : FILL;
      end
      ENDED: ;
      default: state_d = FILL;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FILL;
      dct_buffer  <= '0;
      dct_count   <= '0;
      frame_data  <= '0;
      frame_count <= '0;
      test_ending <= 1'b0;
    end else begin
      state_q     <= state_d;
      dct_buffer  <= buf_d;
      dct_count   <= cnt_d;
      frame_data  <= fdata_d;
      frame_count <= fcnt_d;
      test_ending <= ending_d;
    end
  end

`ifdef DCT_DROP_COUNT_EN
  // Saturating count of the atoms that are discarded outside FILL.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_count <= '0;
    end else if (atom_valid && state_q != FILL && drop_count != '1) begin
      drop_count <= drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_quaddectest_cpu_oci_dct_packer.sv
// Testbench for quaddectest_cpu_oci_dct_packer. It runs directed scenarios
// and then random traffic against a queue-based reference model.
module tb_quaddectest_cpu_oci_dct_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        atom_valid;
  logic [1:0]  atom_data;
  logic        atom_ready;
  logic        flush;
  logic        stop_req;
  logic        frame_valid;
  logic        frame_ready;
  logic [29:0] frame_data;
  logic [3:0]  frame_count;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        test_ending;
  logic        test_has_ended;
`ifdef DCT_DROP_COUNT_EN
  logic [15:0] drop_count;
`endif

  quaddectest_cpu_oci_dct_packer #(.ATOM_W(2), .SLOTS(15), .CNT_W(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .atom_valid     (atom_valid),
    .atom_data      (atom_data),
    .atom_ready     (atom_ready),
    .flush          (flush),
    .stop_req       (stop_req),
    .frame_valid    (frame_valid),
    .frame_ready    (frame_ready),
    .frame_data     (frame_data),
    .frame_count    (frame_count),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended)
`ifdef DCT_DROP_COUNT_EN
    ,
    .drop_count     (drop_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the atoms held in the buffer, plus the frame in flight.
  int          m_atoms[$];
  bit          m_busy;
  logic [29:0] m_fdata;
  int          m_fcnt;
  bit          m_ending;
  bit          m_ended;
  int          m_drop;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [29:0] pack(input int q[$]);
    logic [29:0] v = '0;
    foreach (q[i]) v = v | (30'(q[i]) << (2 * i));
    return v;
  endfunction

  task automatic model_reset();
    m_atoms.delete();
    m_busy = 0; m_fdata = '0; m_fcnt = 0;
    m_ending = 0; m_ended = 0; m_drop = 0;
  endtask

  task automatic model_clock(input bit v, input int d, input bit f, input bit s,
                             input bit r, input bit rs);
    if (rs) begin
      model_reset();
      return;
    end
    if (m_ended) begin
      if (v && m_drop < 65535) m_drop++;
    end else if (m_busy) begin
      if (v && m_drop < 65535) m_drop++;
      if (r) begin
        m_busy = 0;
        if (m_ending || s) m_ended = 1;
      end
    end else begin
      if (v) m_atoms.push_back(d);
      if (m_atoms.size() == 15 || ((f || s) && m_atoms.size() > 0)) begin
        m_fdata = pack(m_atoms);
        m_fcnt  = m_atoms.size();
        m_busy  = 1;
        m_atoms.delete();
      end else if (s) begin
        m_ended = 1;
      end
    end
    if (s) m_ending = 1;
  endtask

  task automatic check_all();
`ifdef DCT_DROP_COUNT_EN
    check("atom_ready", 32'(atom_ready), 32'd1);
    check("drop_count", 32'(drop_count), 32'(m_drop));
`else
    check("atom_ready", 32'(atom_ready), 32'(!m_busy && !m_ended));
`endif
    check("frame_valid", 32'(frame_valid), 32'(m_busy));
    check("dct_count", 32'(dct_count), 32'(m_atoms.size()));
    check("dct_buffer", 32'(dct_buffer), 32'(pack(m_atoms)));
    check("test_ending", 32'(test_ending), 32'(m_ending));
    check("test_has_ended", 32'(test_has_ended), 32'(m_ended));
    if (m_busy) begin
      check("frame_data", 32'(frame_data), 32'(m_fdata));
      check("frame_count", 32'(frame_count), 32'(m_fcnt));
    end
  endtask

  // Applies one cycle of inputs, advances the model at the edge, and checks
  // the outputs on the following falling edge.
  task automatic step(input bit v, input int d, input bit f, input bit s,
                      input bit r, input bit rs);
    reset = rs; atom_valid = v; atom_data = 2'(d);
    flush = f; stop_req = s; frame_ready = r;
    @(posedge clk);
    model_clock(v, d, f, s, r, rs);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    reset = 1'b1; atom_valid = 1'b0; atom_data = '0;
    flush = 1'b0; stop_req = 1'b0; frame_ready = 1'b0;
    model_reset();
    @(negedge clk);
    step(0, 0, 0, 0, 0, 1);
    check("rst_ready", 32'(atom_ready), 32'd1);
    check("rst_fdata", 32'(frame_data), 32'd0);
    check("rst_fcount", 32'(frame_count), 32'd0);

    // Full frame of 15 atoms cycling 1,2,3.
    for (int i = 0; i < 15; i++) step(1, (i % 3) + 1, 0, 0, 1, 0);
    check("full_valid", 32'(frame_valid), 32'd1);
    check("full_count", 32'(frame_count), 32'd15);
    check("full_dcount", 32'(dct_count), 32'd0);
    step(0, 0, 0, 0, 1, 0);
    check("full_release", 32'(frame_valid), 32'd0);

    // Partial flush, then backpressure for 10 cycles.
    step(1, 3, 0, 0, 0, 0);
    step(1, 2, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    check("part_data", 32'(frame_data), 32'h1B);
    check("part_count", 32'(frame_count), 32'd3);
    for (int i = 0; i < 10; i++) step(1, i % 4, 0, 0, 0, 0);
    check("bp_data", 32'(frame_data), 32'h1B);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0, 0);
    check("empty_flush", 32'(frame_valid), 32'd0);

    // Accept, flush and stop together at a count of 4.
    for (int i = 0; i < 4; i++) step(1, i, 0, 0, 0, 0);
    step(1, 3, 1, 1, 0, 0);
    check("sim_count", 32'(frame_count), 32'd5);
    check("sim_ending", 32'(test_ending), 32'd1);
    step(0, 0, 0, 0, 1, 0);
    check("sim_ended", 32'(test_has_ended), 32'd1);

    // Stop when the buffer is empty.
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0);
    check("stop_empty_end", 32'(test_has_ended), 32'd1);
    check("stop_empty_fv", 32'(frame_valid), 32'd0);
    step(1, 2, 0, 0, 1, 0);
    check("stop_refuse", 32'(dct_count), 32'd0);

    // Reset in the middle of EMIT, then a normal full frame.
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 2, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1);
    check("mid_rst_fv", 32'(frame_valid), 32'd0);
    check("mid_rst_fdata", 32'(frame_data), 32'd0);
    for (int i = 0; i < 15; i++) step(1, 3 - (i % 4), 0, 0, 0, 0);
    check("refill_count", 32'(frame_count), 32'd15);
    step(0, 0, 0, 0, 1, 0);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(99) < 70), int'($urandom_range(3)),
           ($urandom_range(99) < 5), ($urandom_range(999) < 3),
           ($urandom_range(99) < 60), ($urandom_range(999) < 5));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
